// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the memory access stage of the multicycle core.
package mem_access_unit_pkg;

  // Access sequencer states; 2-bit encoding keeps the FAULT code at 2'b11.
  typedef enum logic [1:0] {
    MA_IDLE  = 2'b00,
    MA_REQ   = 2'b01,
    MA_DONE  = 2'b10,
    MA_FAULT = 2'b11
  } ma_state_e;

  localparam int MA_DATA_W_DEF  = 32;
  localparam int MA_TIMEOUT_DEF = 64;

  // Word accesses only: any set byte-offset bit is a misaligned access.
  function automatic logic ma_misaligned(input logic [1:0] byte_off);
    return (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Memory-side stage of the multicycle core: converts the control unit's
// MemRead/MemWrite strobes into a req/ack access on a variable-latency memory
// port, steers read data into IR or MDR, and stalls the control unit until the
// access completes. Illegal, misaligned or timed-out accesses park the stage
// in a sticky FAULT state that only reset clears.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W  = MA_DATA_W_DEF,
  parameter int TIMEOUT = MA_TIMEOUT_DEF
) (
  input  logic              cclk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IorD,
  input  logic              IrWrite,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] mdr,
  output logic              fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  // Counter only needs to reach TIMEOUT-1, which fits in clog2(TIMEOUT) bits.
  localparam int                CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  ma_state_e          state_q, state_d;
  logic [DATA_W-1:0]  addr_q,  addr_d;
  logic [DATA_W-1:0]  wdat_q,  wdat_d;
  logic               we_q,    we_d;
  logic               dst_q,   dst_d;
  logic [DATA_W-1:0]  instr_q, instr_d;
  logic [DATA_W-1:0]  mdr_q,   mdr_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic               acc;
  logic [DATA_W-1:0]  sel_addr;

  assign acc      = MemRead | MemWrite;
  assign sel_addr = IorD ? alu_out : pc;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state_q <= MA_IDLE;
      addr_q  <= '0;
      wdat_q  <= '0;
      we_q    <= 1'b0;
      dst_q   <= 1'b0;
      instr_q <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
      dst_q   <= dst_d;
      instr_q <= instr_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, request capture, read-data steering and stall generation.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    we_d    = we_q;
    dst_d   = dst_q;
    instr_d = instr_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;

    case (state_q)
      MA_IDLE: begin
        // A stray mem_ack here is deliberately ignored.
        if (acc) begin
          stall = 1'b1;
          if (MemRead & MemWrite) begin
            state_d = MA_FAULT;
          end else if (ma_misaligned(sel_addr[1:0])) begin
            state_d = MA_FAULT;
          end else begin
            addr_d  = sel_addr;
            we_d    = MemWrite;
            wdat_d  = wdata;
            dst_d   = IrWrite;
            cnt_d   = '0;
            state_d = MA_REQ;
          end
        end else begin
          state_d = MA_IDLE;
        end
      end

      MA_REQ: begin
        stall = 1'b1;
        if (mem_ack) begin
          if (!we_q) begin
            if (dst_q) begin
              instr_d = mem_rdata;
            end else begin
              mdr_d = mem_rdata;
            end
          end else begin
            instr_d = instr_q;
          end
          state_d = MA_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = MA_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // One stall-free cycle so the control unit advances before strobes are
      // looked at again; otherwise the completing state's strobes would
      // launch a duplicate access.
      MA_DONE: begin
        stall   = 1'b0;
        state_d = MA_IDLE;
      end

      MA_FAULT: begin
        stall   = 1'b1;
        state_d = MA_FAULT;
      end

      default: begin
        stall   = 1'b1;
        state_d = MA_FAULT;
      end
    endcase
  end

  assign mem_req   = (state_q == MA_REQ);
  assign fault     = (state_q == MA_FAULT);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdat_q;
  assign instr     = instr_q;
  assign mdr       = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: fetch, load, store, fault paths, timeout
// and asynchronous reset in the middle of a request.
module tb_mem_access_unit;

  localparam int DW  = 32;
  localparam int TMO = 64;

  logic          cclk = 1'b0;
  logic          rst;
  logic          MemRead, MemWrite, IorD, IrWrite;
  logic [DW-1:0] pc, alu_out, wdata;
  logic          stall, fault, mem_req, mem_we, mem_ack;
  logic [DW-1:0] instr, mdr, mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 cclk = ~cclk;

  mem_access_unit #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
    .cclk      (cclk),
    .rst       (rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .IorD      (IorD),
    .IrWrite   (IrWrite),
    .pc        (pc),
    .alu_out   (alu_out),
    .wdata     (wdata),
    .stall     (stall),
    .instr     (instr),
    .mdr       (mdr),
    .fault     (fault),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_strobes();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IrWrite  = 1'b0;
    mem_ack  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge cclk);
    clear_strobes();
    rst = 1'b1;
    @(negedge cclk);
    rst = 1'b0;
  endtask

  // Called just after a negedge with strobes applied. Acks in REQ cycle
  // ack_at, holds strobes through DONE, then watches for a duplicate request.
  task automatic run_access(input int ack_at, input logic [31:0] rd,
                            output int stall_cnt, output int bursts,
                            output logic [31:0] a0, output logic we0,
                            output logic [31:0] wd0, output logic stable);
    int   req_cnt;
    logic prev_req;
    logic done;
    stall_cnt = 0; bursts = 0; req_cnt = 0; prev_req = 1'b0; done = 1'b0;
    a0 = '0; we0 = 1'b0; wd0 = '0; stable = 1'b1;
    #1;
    for (int c = 0; c < 200 && !done; c++) begin
      if (mem_req && !prev_req) bursts++;
      prev_req = mem_req;
      if (mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          a0 = mem_addr; we0 = mem_we; wd0 = mem_wdata;
        end else if (mem_addr !== a0 || mem_we !== we0 || mem_wdata !== wd0) begin
          stable = 1'b0;
        end
      end
      if (stall) stall_cnt++;
      if (mem_req && req_cnt == ack_at) begin
        mem_ack = 1'b1; mem_rdata = rd;
      end else begin
        mem_ack = 1'b0;
      end
      if (!stall && c > 0) begin
        done = 1'b1;
      end else begin
        @(negedge cclk);
        #1;
      end
    end
    check_val("access_completes", {31'd0, done}, 32'd1);
    @(posedge cclk);
    #1;
    clear_strobes();
    for (int k = 0; k < 3; k++) begin
      @(negedge cclk);
      if (mem_req && !prev_req) bursts++;
      prev_req = mem_req;
    end
  endtask

  int          sc, nb;
  logic [31:0] a0, wd0;
  logic        we0, stb;

  initial begin
    rst = 1'b1;
    clear_strobes();
    pc = '0; alu_out = '0; wdata = '0; mem_rdata = '0;
    #2;
    check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_fault",   {31'd0, fault},   32'd0);
    check_val("rst_instr",   instr,            32'h0);
    check_val("rst_mdr",     mdr,              32'h0);
    check_val("rst_addr",    mem_addr,         32'h0);
    @(negedge cclk);
    rst = 1'b0;

    // 1: instruction fetch, ack in third REQ cycle
    @(negedge cclk);
    pc = 32'h40; MemRead = 1'b1; IrWrite = 1'b1; IorD = 1'b0;
    run_access(3, 32'h8C220004, sc, nb, a0, we0, wd0, stb);
    check_val("fetch_addr",   a0,             32'h40);
    check_val("fetch_we",     {31'd0, we0},   32'd0);
    check_val("fetch_stall",  sc,             32'd4);
    check_val("fetch_instr",  instr,          32'h8C220004);
    check_val("fetch_mdr",    mdr,            32'h0);
    check_val("fetch_bursts", nb,             32'd1);

    // 2: load through alu_out, ack in first REQ cycle
    @(negedge cclk);
    alu_out = 32'h100; IorD = 1'b1; IrWrite = 1'b0; MemRead = 1'b1;
    run_access(1, 32'hDEADBEEF, sc, nb, a0, we0, wd0, stb);
    check_val("load_addr",   a0,    32'h100);
    check_val("load_mdr",    mdr,   32'hDEADBEEF);
    check_val("load_instr",  instr, 32'h8C220004);
    check_val("load_stall",  sc,    32'd2);
    check_val("load_bursts", nb,    32'd1);

    // 3: store, ack in second REQ cycle; read data bus carries junk
    @(negedge cclk);
    alu_out = 32'h200; wdata = 32'h12345678; IorD = 1'b1; MemWrite = 1'b1;
    run_access(2, 32'hA5A5A5A5, sc, nb, a0, we0, wd0, stb);
    check_val("store_we",     {31'd0, we0}, 32'd1);
    check_val("store_addr",   a0,           32'h200);
    check_val("store_wdata",  wd0,          32'h12345678);
    check_val("store_stable", {31'd0, stb}, 32'd1);
    check_val("store_stall",  sc,           32'd3);
    check_val("store_instr",  instr,        32'h8C220004);
    check_val("store_mdr",    mdr,          32'hDEADBEEF);
    check_val("store_bursts", nb,           32'd1);

    // 4a: read and write together
    @(negedge cclk);
    MemRead = 1'b1; MemWrite = 1'b1;
    #1;
    check_val("rw_stall_idle", {31'd0, stall}, 32'd1);
    @(negedge cclk);
    check_val("rw_fault", {31'd0, fault},   32'd1);
    check_val("rw_req",   {31'd0, mem_req}, 32'd0);
    do_reset();

    // 4b: misaligned data address
    @(negedge cclk);
    alu_out = 32'h102; IorD = 1'b1; MemRead = 1'b1;
    @(negedge cclk);
    check_val("mis_fault", {31'd0, fault},   32'd1);
    check_val("mis_req",   {31'd0, mem_req}, 32'd0);
    @(negedge cclk);
    check_val("mis_sticky", {31'd0, fault},  32'd1);
    do_reset();

    // 4c: no ack ever -> timeout after TMO request cycles
    @(negedge cclk);
    pc = 32'h80; IorD = 1'b0; MemRead = 1'b1; IrWrite = 1'b1;
    sc = 0;
    for (int c = 0; c < 200 && !fault; c++) begin
      @(negedge cclk);
      if (mem_req) sc++;
    end
    check_val("tmo_req_cycles", sc,               TMO);
    check_val("tmo_fault",      {31'd0, fault},   32'd1);
    check_val("tmo_req",        {31'd0, mem_req}, 32'd0);
    MemRead = 1'b0;
    #1;
    check_val("tmo_stall",      {31'd0, stall},   32'd1);
    do_reset();

    // Refill IR/MDR so the reset test below observes a real clear
    @(negedge cclk);
    pc = 32'h44; MemRead = 1'b1; IrWrite = 1'b1; IorD = 1'b0;
    run_access(1, 32'h11112222, sc, nb, a0, we0, wd0, stb);
    @(negedge cclk);
    alu_out = 32'h104; IorD = 1'b1; MemRead = 1'b1;
    run_access(1, 32'h33334444, sc, nb, a0, we0, wd0, stb);
    check_val("refill_instr", instr, 32'h11112222);
    check_val("refill_mdr",   mdr,   32'h33334444);

    // 5: reset while a request is outstanding
    @(negedge cclk);
    pc = 32'h48; IorD = 1'b0; MemRead = 1'b1; IrWrite = 1'b1;
    @(negedge cclk);
    check_val("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #1;
    rst = 1'b1;
    clear_strobes();
    #1;
    check_val("midrst_req",   {31'd0, mem_req}, 32'd0);
    check_val("midrst_stall", {31'd0, stall},   32'd0);
    check_val("midrst_fault", {31'd0, fault},   32'd0);
    check_val("midrst_instr", instr,            32'h0);
    check_val("midrst_mdr",   mdr,              32'h0);
    @(negedge cclk);
    rst = 1'b0;
    @(negedge cclk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
    @(negedge cclk);
    mem_ack = 1'b0;
    #1;
    check_val("stray_req",   {31'd0, mem_req}, 32'd0);
    check_val("stray_stall", {31'd0, stall},   32'd0);
    check_val("stray_instr", instr,            32'h0);
    check_val("stray_mdr",   mdr,              32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
